// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset constants and the fetch-stage action encoding.
package cpu_pkg;

    localparam int              INST_W   = 32;
    localparam int              CNT_W    = 32;
    localparam logic [31:0]     RESET_PC = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    // One action per clock edge, listed in decreasing priority.
    typedef enum logic [2:0] {
        HOLD,
        REDIRECT_BR,
        REDIRECT_J,
        STALL,
        ADVANCE
    } fetch_action_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a NOP bubble, load captures a fetch, otherwise hold.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int                PC_W     = 32,
    parameter logic [INST_W-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic [PC_W-1:0]   pc4_i,
    input  logic [INST_W-1:0] inst_i,
    output logic [PC_W-1:0]   pc4_o,
    output logic [INST_W-1:0] inst_o,
    output logic              valid_o
);

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc4_o   <= '0;
            inst_o  <= NOP_INST;
            valid_o <= 1'b0;
        end else if (flush_i) begin
            pc4_o   <= '0;
            inst_o  <= NOP_INST;
            valid_o <= 1'b0;
        end else if (load_i) begin
            pc4_o   <= pc4_i;
            inst_o  <= inst_i;
            valid_o <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, redirect/stall priority, IF/ID register and perf counters.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                PC_W     = 32,
    parameter logic [PC_W-1:0]   RESET_PC = PC_W'(cpu_pkg::RESET_PC),
    parameter int                CNT_W    = cpu_pkg::CNT_W,
    parameter logic [INST_W-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              jump_i,
    input  logic [PC_W-1:0]   jump_target_i,
    input  logic              branch_i,
    input  logic [PC_W-1:0]   branch_target_i,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic [INST_W-1:0] imem_inst_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [PC_W-1:0]   id_pc4_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_valid_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic [CNT_W-1:0]  cycle_cnt_o
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    fetch_action_e   action;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_plus4;

    assign pc_plus4 = pc_q + PC_W'(4);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        action = ADVANCE;
        pc_d   = pc_q;
        if (!start_i)      action = HOLD;
        else if (branch_i) action = REDIRECT_BR;
        else if (jump_i)   action = REDIRECT_J;
        else if (stall_i)  action = STALL;

        unique case (action)
            REDIRECT_BR: pc_d = branch_target_i & ALIGN_MASK;
            REDIRECT_J:  pc_d = jump_target_i & ALIGN_MASK;
            ADVANCE:     pc_d = pc_plus4;
            default:     pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    assign pc_o        = pc_q;
    assign imem_addr_o = pc_q;

    if_id_reg #(
        .PC_W     (PC_W),
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (action == ADVANCE),
        .flush_i (action == REDIRECT_BR || action == REDIRECT_J),
        .pc4_i   (pc_plus4),
        .inst_i  (imem_inst_i),
        .pc4_o   (id_pc4_o),
        .inst_o  (id_inst_o),
        .valid_o (id_valid_o)
    );

    // Counters only observe cycles in which the pipeline is running.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
            cycle_cnt_o <= '0;
        end else if (start_i) begin
            cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
            if (action == STALL)
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (action == REDIRECT_BR || action == REDIRECT_J)
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; imem returns addr ^ 32'hDEAD_0000.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, stall = 1'b0, jump = 1'b0, branch = 1'b0;
    logic [31:0] jump_target = '0, branch_target = '0;
    logic [31:0] imem_addr, imem_inst, pc, id_pc4, id_inst;
    logic        id_valid;
    logic [31:0] stall_cnt, flush_cnt, cycle_cnt;

    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    assign imem_inst = imem_addr ^ 32'hDEAD_0000;

    fetch_stage dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .stall_i         (stall),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .branch_i        (branch),
        .branch_target_i (branch_target),
        .imem_addr_o     (imem_addr),
        .imem_inst_i     (imem_inst),
        .pc_o            (pc),
        .id_pc4_o        (id_pc4),
        .id_inst_o       (id_inst),
        .id_valid_o      (id_valid),
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt),
        .cycle_cnt_o     (cycle_cnt)
    );

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {start, stall, jump, branch} = 4'b0000;
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        assertions++;
        if ({pc, imem_addr, id_pc4, id_inst, id_valid} !== {32'h0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_if: pc=%h addr=%h pc4=%h inst=%h v=%b expected all zero", pc, imem_addr, id_pc4, id_inst, id_valid);
        end
        assertions++;
        if ({stall_cnt, flush_cnt, cycle_cnt} !== 96'h0) begin
            failures++;
            $display("FAIL reset_cnt: stall=%0d flush=%0d cycle=%0d expected 0 0 0", stall_cnt, flush_cnt, cycle_cnt);
        end
    endtask

    task automatic test_advance();
        logic [31:0] exp_pc [4]   = '{32'h4, 32'h8, 32'hC, 32'h10};
        logic [31:0] exp_inst [4] = '{32'hDEAD_0000, 32'hDEAD_0004, 32'hDEAD_0008, 32'hDEAD_000C};
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            assertions++;
            if ({pc, id_inst, id_pc4, id_valid} !== {exp_pc[i], exp_inst[i], exp_pc[i], 1'b1}) begin
                failures++;
                $display("FAIL advance[%0d]: pc=%h inst=%h pc4=%h v=%b expected pc=%h inst=%h pc4=%h v=1",
                         i, pc, id_inst, id_pc4, id_valid, exp_pc[i], exp_inst[i], exp_pc[i]);
            end
        end
        assertions++;
        if (cycle_cnt !== 32'd4) begin
            failures++;
            $display("FAIL advance_cycles: got %0d expected 4", cycle_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        start = 1'b1;
        step();
        step();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            assertions++;
            if ({pc, id_inst, id_pc4, id_valid} !== {32'h8, 32'hDEAD_0004, 32'h8, 1'b1}) begin
                failures++;
                $display("FAIL stall_hold[%0d]: pc=%h inst=%h pc4=%h v=%b expected pc=8 inst=dead0004 pc4=8 v=1",
                         i, pc, id_inst, id_pc4, id_valid);
            end
        end
        assertions++;
        if ({stall_cnt, flush_cnt, cycle_cnt} !== {32'd2, 32'd0, 32'd4}) begin
            failures++;
            $display("FAIL stall_cnt: stall=%0d flush=%0d cycle=%0d expected 2 0 4", stall_cnt, flush_cnt, cycle_cnt);
        end
        stall = 1'b0;
        step();
        assertions++;
        if ({pc, id_inst, id_pc4} !== {32'hC, 32'hDEAD_0008, 32'hC}) begin
            failures++;
            $display("FAIL stall_resume: pc=%h inst=%h pc4=%h expected pc=c inst=dead0008 pc4=c", pc, id_inst, id_pc4);
        end
    endtask

    task automatic test_branch();
        branch = 1'b1;
        branch_target = 32'h40;
        step();
        branch = 1'b0;
        assertions++;
        if ({pc, id_inst, id_pc4, id_valid, flush_cnt} !== {32'h40, 32'h0, 32'h0, 1'b0, 32'd1}) begin
            failures++;
            $display("FAIL branch_flush: pc=%h inst=%h pc4=%h v=%b flush=%0d expected pc=40 inst=0 pc4=0 v=0 flush=1",
                     pc, id_inst, id_pc4, id_valid, flush_cnt);
        end
        step();
        assertions++;
        if ({pc, id_inst, id_pc4, id_valid} !== {32'h44, 32'hDEAD_0040, 32'h44, 1'b1}) begin
            failures++;
            $display("FAIL branch_target_fetch: pc=%h inst=%h pc4=%h v=%b expected pc=44 inst=dead0040 pc4=44 v=1",
                     pc, id_inst, id_pc4, id_valid);
        end
    endtask

    task automatic test_priority();
        {jump, branch, stall} = 3'b111;
        jump_target   = 32'h80;
        branch_target = 32'h20;
        step();
        assertions++;
        if ({pc, id_valid, flush_cnt, stall_cnt} !== {32'h20, 1'b0, 32'd2, 32'd2}) begin
            failures++;
            $display("FAIL prio_branch_wins: pc=%h v=%b flush=%0d stall=%0d expected pc=20 v=0 flush=2 stall=2",
                     pc, id_valid, flush_cnt, stall_cnt);
        end
        {jump, branch, stall} = 3'b100;
        jump_target = 32'h83;
        step();
        jump = 1'b0;
        assertions++;
        if ({pc, flush_cnt} !== {32'h80, 32'd3}) begin
            failures++;
            $display("FAIL jump_align: pc=%h flush=%0d expected pc=80 flush=3", pc, flush_cnt);
        end
    endtask

    task automatic test_start_low();
        step();
        start = 1'b0;
        {stall, jump, branch} = 3'b111;
        for (int i = 0; i < 3; i++) begin
            step();
            assertions++;
            if ({pc, id_inst, id_pc4, id_valid, stall_cnt, flush_cnt, cycle_cnt} !==
                {32'h84, 32'hDEAD_0080, 32'h84, 1'b1, 32'd2, 32'd3, 32'd10}) begin
                failures++;
                $display("FAIL start_low_freeze[%0d]: pc=%h inst=%h pc4=%h v=%b s=%0d f=%0d c=%0d expected 84 dead0080 84 1 2 3 10",
                         i, pc, id_inst, id_pc4, id_valid, stall_cnt, flush_cnt, cycle_cnt);
            end
        end
        {stall, jump, branch} = 3'b000;
        start = 1'b1;
        step();
        assertions++;
        if ({pc, id_inst, cycle_cnt} !== {32'h88, 32'hDEAD_0084, 32'd11}) begin
            failures++;
            $display("FAIL start_resume: pc=%h inst=%h cycle=%0d expected pc=88 inst=dead0084 cycle=11", pc, id_inst, cycle_cnt);
        end
    endtask

    task automatic test_async_reset();
        jump = 1'b1;
        jump_target = 32'h20;
        step();
        jump = 1'b0;
        step();
        assertions++;
        if (pc !== 32'h24) begin
            failures++;
            $display("FAIL async_setup: pc=%h expected 24", pc);
        end
        #2;
        rst = 1'b0;
        #1;
        assertions++;
        if ({pc, id_valid, id_inst, stall_cnt, flush_cnt, cycle_cnt} !== {32'h0, 1'b0, 32'h0, 96'h0}) begin
            failures++;
            $display("FAIL async_reset: pc=%h v=%b inst=%h s=%0d f=%0d c=%0d expected all zero",
                     pc, id_valid, id_inst, stall_cnt, flush_cnt, cycle_cnt);
        end
        step();
        rst = 1'b1;
        step();
        assertions++;
        if ({pc, id_inst, cycle_cnt} !== {32'h4, 32'hDEAD_0000, 32'd1}) begin
            failures++;
            $display("FAIL async_release: pc=%h inst=%h cycle=%0d expected pc=4 inst=dead0000 cycle=1", pc, id_inst, cycle_cnt);
        end
    endtask

    task automatic test_pc_wrap();
        jump = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        step();
        jump = 1'b0;
        step();
        assertions++;
        if ({pc, id_inst, id_pc4, id_valid} !== {32'h0, 32'h2152_FFFC, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL pc_wrap: pc=%h inst=%h pc4=%h v=%b expected pc=0 inst=2152fffc pc4=0 v=1", pc, id_inst, id_pc4, id_valid);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_advance();
        test_stall();
        test_branch();
        test_priority();
        test_start_low();
        test_async_reset();
        test_pc_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
